// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - SUBLEQ instruction sequencer driving a req/ack memory port and the A register
module subleq_sequencer #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 run,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 a_set,
    output logic [WORD_SIZE-1:0] a_in,
    input  logic [WORD_SIZE-1:0] a_out,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 halted
);

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_B = 3'd1,
        FETCH_C = 3'd2,
        LOAD_A  = 3'd3,
        LOAD_B  = 3'd4,
        WRITE   = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [WORD_SIZE-1:0] STEP1 = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] STEP2 = WORD_SIZE'(2);
    localparam logic [WORD_SIZE-1:0] STEP3 = WORD_SIZE'(3);

    state_t               state_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] addr_a_q;
    logic [WORD_SIZE-1:0] addr_b_q;
    logic [WORD_SIZE-1:0] addr_c_q;
    logic [WORD_SIZE-1:0] b_val_q;
    // Low for the first cycle after reset so the port is quiet while reset is held
    logic                 live_q;

    logic [WORD_SIZE-1:0] result;
    logic                 leq;
    logic                 xfer;

    // Subtraction result and branch condition for the WRITE step
    always_comb begin
        result = b_val_q - a_out;
        leq    = result[WORD_SIZE-1] | (result == '0);
    end

    // Memory port decode from the registered state
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        unique case (state_q)
            FETCH_A: begin
                mem_req  = live_q & run;
                mem_addr = pc_q;
            end
            FETCH_B: begin
                mem_req  = 1'b1;
                mem_addr = pc_q + STEP1;
            end
            FETCH_C: begin
                mem_req  = 1'b1;
                mem_addr = pc_q + STEP2;
            end
            LOAD_A: begin
                mem_req  = 1'b1;
                mem_addr = addr_a_q;
            end
            LOAD_B: begin
                mem_req  = 1'b1;
                mem_addr = addr_b_q;
            end
            WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_b_q;
            end
            HALT: begin
                mem_req  = 1'b0;
            end
            default: begin
                mem_req  = 1'b0;
            end
        endcase
    end

    // Remaining outputs; a_set fires only on the completing edge of the LOAD_A read
    always_comb begin
        xfer      = mem_req & mem_ack;
        mem_wdata = result;
        a_in      = mem_rdata;
        a_set     = (state_q == LOAD_A) & xfer;
        pc        = pc_q;
        halted    = (state_q == HALT);
    end

    // Sequencer state: advances only on a completed transaction
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q  <= FETCH_A;
            pc_q     <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            b_val_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (xfer) begin
                unique case (state_q)
                    FETCH_A: begin
                        addr_a_q <= mem_rdata;
                        state_q  <= FETCH_B;
                    end
                    FETCH_B: begin
                        addr_b_q <= mem_rdata;
                        state_q  <= FETCH_C;
                    end
                    FETCH_C: begin
                        addr_c_q <= mem_rdata;
                        state_q  <= LOAD_A;
                    end
                    LOAD_A: begin
                        state_q  <= LOAD_B;
                    end
                    LOAD_B: begin
                        b_val_q  <= mem_rdata;
                        state_q  <= WRITE;
                    end
                    WRITE: begin
                        if (leq && (&addr_c_q)) begin
                            state_q <= HALT;
                        end else if (leq) begin
                            pc_q    <= addr_c_q;
                            state_q <= FETCH_A;
                        end else begin
                            pc_q    <= pc_q + STEP3;
                            state_q <= FETCH_A;
                        end
                    end
                    HALT: begin
                        state_q <= HALT;
                    end
                    default: begin
                        state_q <= HALT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// tb/tb_subleq_sequencer.sv - self-checking bench for subleq_sequencer
module tb_subleq_sequencer;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic        aload;
    } txn_t;

    logic        clk;
    logic        areset;
    logic        run;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        a_set;
    logic [15:0] a_in;
    logic [15:0] a_reg;
    logic [15:0] pc;
    logic        halted;

    logic [15:0] mem [0:65535];
    int          wait_n;
    int          wait_cnt;
    int          total;
    int          bad;
    txn_t        exp_q[$];

    logic        prv_pend;
    logic [15:0] prv_addr;
    logic        prv_we;
    logic [15:0] prv_wdata;

    subleq_sequencer #(.WORD_SIZE(16)) dut (
        .clk       (clk),
        .areset    (areset),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .a_set     (a_set),
        .a_in      (a_in),
        .a_out     (a_reg),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = (wait_cnt == wait_n);

    always @(posedge clk) begin
        if (!areset)                 wait_cnt <= 0;
        else if (mem_req && mem_ack) wait_cnt <= 0;
        else if (mem_req)            wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk or negedge areset) begin
        if (!areset)    a_reg <= '0;
        else if (a_set) a_reg <= a_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_writer();
        forever begin
            @(posedge clk);
            if (areset && mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
        end
    endtask

    task automatic monitor();
        txn_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!areset) begin
                prv_pend = 1'b0;
            end else begin
                if (prv_pend) begin
                    chk("hold_req", 32'(mem_req), 32'(1'b1));
                    chk("hold_addr", 32'(mem_addr), 32'(prv_addr));
                    chk("hold_we", 32'(mem_we), 32'(prv_we));
                    chk("hold_wdata", 32'(mem_wdata), 32'(prv_wdata));
                end
                if (mem_req && mem_ack) begin
                    chk("txn_expected", 32'(exp_q.size() != 0), 32'(1'b1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("txn_we", 32'(mem_we), 32'(e.we));
                        chk("txn_addr", 32'(mem_addr), 32'(e.addr));
                        chk("txn_a_set", 32'(a_set), 32'(e.aload));
                        if (e.we)    chk("txn_wdata", 32'(mem_wdata), 32'(e.data));
                        if (e.aload) chk("txn_a_in", 32'(a_in), 32'(e.data));
                    end
                end
                prv_pend  = mem_req && !mem_ack;
                prv_addr  = mem_addr;
                prv_we    = mem_we;
                prv_wdata = mem_wdata;
            end
        end
    endtask

    task automatic push_txn(input logic we, input logic [15:0] addr, input logic [15:0] data,
                            input logic aload);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data; t.aload = aload;
        exp_q.push_back(t);
    endtask

    task automatic push_instr(input logic [15:0] ipc, input logic [15:0] aa, input logic [15:0] ab,
                              input logic [15:0] va, input logic [15:0] vb);
        logic [15:0] p1, p2, res;
        p1  = ipc + 16'd1;
        p2  = ipc + 16'd2;
        res = vb - va;
        push_txn(1'b0, ipc, 16'h0, 1'b0);
        push_txn(1'b0, p1, 16'h0, 1'b0);
        push_txn(1'b0, p2, 16'h0, 1'b0);
        push_txn(1'b0, aa, va, 1'b1);
        push_txn(1'b0, ab, 16'h0, 1'b0);
        push_txn(1'b1, ab, res, 1'b0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    endtask

    task automatic exec(input int ncyc);
        run = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == wait_n + 1) run = 1'b0;
        end
    endtask

    task automatic hold_reset();
        areset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        prv_pend = 1'b0;
        wait_n   = 0;
        run      = 1'b1;
        areset   = 1'b0;
        clear_mem();
        fork
            mem_writer();
            monitor();
        join_none

        mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd20;
        mem[10] = 16'd3; mem[11] = 16'd5;
        push_instr(16'd0, 16'd10, 16'd11, 16'd3, 16'd5);
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'(1'b0));
        chk("rst_we", 32'(mem_we), 32'(1'b0));
        chk("rst_a_set", 32'(a_set), 32'(1'b0));
        chk("rst_halted", 32'(halted), 32'(1'b0));
        chk("rst_pc", 32'(pc), 32'(16'h0));
        areset = 1'b1;
        @(negedge clk);
        chk("rel_req", 32'(mem_req), 32'(1'b1));
        chk("rel_addr", 32'(mem_addr), 32'(16'h0));

        exec(6);
        chk("pos_pc", 32'(pc), 32'(16'd3));
        chk("pos_mem", 32'(mem[11]), 32'(16'd2));
        chk("pos_areg", 32'(a_reg), 32'(16'd3));
        chk("pos_idle_req", 32'(mem_req), 32'(1'b0));
        chk("pos_q_empty", 32'(exp_q.size()), 32'(0));

        mem[3] = 16'd12; mem[4] = 16'd13; mem[5] = 16'd20;
        mem[12] = 16'd3; mem[13] = 16'd3;
        push_instr(16'd3, 16'd12, 16'd13, 16'd3, 16'd3);
        exec(6);
        chk("zero_pc", 32'(pc), 32'(16'd20));
        chk("zero_mem", 32'(mem[13]), 32'(16'h0));

        mem[20] = 16'd14; mem[21] = 16'd15; mem[22] = 16'd40;
        mem[14] = 16'd3; mem[15] = 16'd1;
        push_instr(16'd20, 16'd14, 16'd15, 16'd3, 16'd1);
        exec(6);
        chk("neg_pc", 32'(pc), 32'(16'd40));
        chk("neg_mem", 32'(mem[15]), 32'(16'hFFFE));

        mem[40] = 16'd16; mem[41] = 16'd17; mem[42] = 16'hFFFF;
        mem[16] = 16'd5; mem[17] = 16'd5;
        push_instr(16'd40, 16'd16, 16'd17, 16'd5, 16'd5);
        exec(6);
        chk("halt_flag", 32'(halted), 32'(1'b1));
        chk("halt_req", 32'(mem_req), 32'(1'b0));
        chk("halt_pc", 32'(pc), 32'(16'd40));
        chk("halt_mem", 32'(mem[17]), 32'(16'h0));
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt_hold_req", 32'(mem_req), 32'(1'b0));
        chk("halt_hold_flag", 32'(halted), 32'(1'b1));
        chk("halt_q_empty", 32'(exp_q.size()), 32'(0));

        run = 1'b0;
        hold_reset();
        chk("rst2_halted", 32'(halted), 32'(1'b0));
        wait_n = 3;
        clear_mem();
        mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd20;
        mem[10] = 16'd3; mem[11] = 16'd5;
        push_instr(16'd0, 16'd10, 16'd11, 16'd3, 16'd5);
        areset = 1'b1;
        @(negedge clk);
        chk("run0_req", 32'(mem_req), 32'(1'b0));
        exec(23);
        chk("wait23_req", 32'(mem_req), 32'(1'b1));
        chk("wait23_we", 32'(mem_we), 32'(1'b1));
        chk("wait23_pc", 32'(pc), 32'(16'd0));
        @(negedge clk);
        chk("wait24_pc", 32'(pc), 32'(16'd3));
        chk("wait24_req", 32'(mem_req), 32'(1'b0));
        chk("wait_mem", 32'(mem[11]), 32'(16'd2));
        chk("wait_q_empty", 32'(exp_q.size()), 32'(0));

        wait_n = 0;
        hold_reset();
        clear_mem();
        mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd20;
        mem[10] = 16'd3; mem[11] = 16'd5;
        push_instr(16'd0, 16'd10, 16'd11, 16'd3, 16'd5);
        run    = 1'b1;
        areset = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
        end
        wait_n = 50;
        chk("mid_req", 32'(mem_req), 32'(1'b1));
        chk("mid_we", 32'(mem_we), 32'(1'b1));
        chk("mid_addr", 32'(mem_addr), 32'(16'd11));
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'(1'b0));
        chk("abort_we", 32'(mem_we), 32'(1'b0));
        chk("abort_pc", 32'(pc), 32'(16'd0));
        chk("abort_mem", 32'(mem[11]), 32'(16'd5));
        chk("abort_q_left", 32'(exp_q.size()), 32'(1));
        exp_q.delete();
        wait_n = 0;
        push_instr(16'd0, 16'd10, 16'd11, 16'd3, 16'd5);
        @(negedge clk);
        @(negedge clk);
        run    = 1'b1;
        areset = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(mem_req), 32'(1'b1));
        chk("restart_addr", 32'(mem_addr), 32'(16'h0));
        exec(6);
        chk("restart_pc", 32'(pc), 32'(16'd3));
        chk("restart_mem", 32'(mem[11]), 32'(16'd2));

        run = 1'b0;
        hold_reset();
        clear_mem();
        mem[0] = 16'd30; mem[1] = 16'd31; mem[2] = 16'hFFFE;
        mem[30] = 16'd1; mem[31] = 16'd1;
        mem[16'hFFFE] = 16'd32; mem[16'hFFFF] = 16'd33;
        mem[32] = 16'd1; mem[33] = 16'd5;
        push_instr(16'd0, 16'd30, 16'd31, 16'd1, 16'd1);
        push_instr(16'hFFFE, 16'd32, 16'd33, 16'd1, 16'd5);
        areset = 1'b1;
        @(negedge clk);
        exec(6);
        chk("wrap_jump_pc", 32'(pc), 32'(16'hFFFE));
        exec(6);
        chk("wrap_pc", 32'(pc), 32'(16'h0001));
        chk("wrap_mem", 32'(mem[33]), 32'(16'd4));
        chk("wrap_q_empty", 32'(exp_q.size()), 32'(0));
        repeat (3) @(negedge clk);
        chk("wrap_idle_req", 32'(mem_req), 32'(1'b0));
        chk("wrap_idle_pc", 32'(pc), 32'(16'h0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
